// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline types for forwarding selects and hazard FSM state.
package pipe_pkg;
    typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hz_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-to-hazard-controller signal bundle.
interface pipe_hazard_ctrl_if #(parameter int REG_AW = 5, parameter int CNT_W = 32);
    logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic load_e, take_branch_e, reg_write_m, reg_write_w, mem_req_m, mem_ready_m;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
    pipe_pkg::fwd_sel_t forward_a_e, forward_b_e;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, lu_cnt;
    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output load_e, take_branch_e, reg_write_m, reg_write_w, mem_req_m, mem_ready_m,
        input stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err,
        input forward_a_e, forward_b_e, stall_cnt, flush_cnt, lu_cnt
    );
    modport slave (
        input rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input load_e, take_branch_e, reg_write_m, reg_write_w, mem_req_m, mem_ready_m,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err,
        output forward_a_e, forward_b_e, stall_cnt, flush_cnt, lu_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(parameter int CNT_W = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;
    always_comb count_d = (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
    assign count = count_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/branch/memory-wait hazard control, M/W forwarding
// and saturating performance counters for the 5-stage pipeline.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
    hz_state_t state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic mem_err_q, mem_err_d;
    logic memstall, lu, br, timeout;

    function automatic fwd_sel_t fwd(input logic [REG_AW-1:0] x, input logic [REG_AW-1:0] rd_m,
                                     input logic wm, input logic [REG_AW-1:0] rd_w, input logic ww);
        return x == '0 ? FWD_REG : (wm && rd_m == x) ? FWD_M : (ww && rd_w == x) ? FWD_W : FWD_REG;
    endfunction

    always_comb begin
        timeout  = MEM_TIMEOUT != 0 && wait_q + 1'b1 == WW'(MEM_TIMEOUT);
        memstall = !rst && !hz.mem_ready_m && (state_q == MEM_WAIT || hz.mem_req_m);
        br       = !rst && !memstall && hz.take_branch_e;
        // A taken branch squashes the load-use pair, so it is neither stalled nor counted.
        lu       = !rst && !memstall && !hz.take_branch_e && hz.load_e && hz.rd_e != '0 &&
                   (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
        state_d  = state_q == RUN ? ((hz.mem_req_m && !hz.mem_ready_m) ? MEM_WAIT : RUN)
                                  : ((hz.mem_ready_m || timeout) ? RUN : MEM_WAIT);
        wait_d   = state_q == RUN ? '0 : wait_q + 1'b1;
        mem_err_d = mem_err_q || (state_q == MEM_WAIT && !hz.mem_ready_m && timeout);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign hz.stall_f     = memstall || lu;
    assign hz.stall_d     = memstall || lu;
    assign hz.stall_e     = memstall;
    assign hz.stall_m     = memstall;
    assign hz.flush_d     = br;
    assign hz.flush_e     = br || lu;
    assign hz.flush_w     = memstall;
    assign hz.mem_err     = mem_err_q;
    assign hz.forward_a_e = rst ? FWD_REG : fwd(hz.rs1_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);
    assign hz.forward_b_e = rst ? FWD_REG : fwd(hz.rs2_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(hz.stall_f), .count(hz.stall_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(br), .count(hz.flush_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (.clk(clk), .rst(rst), .inc(lu), .count(hz.lu_cnt));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: randomized + directed scoreboard bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
    localparam int CW = 3;
    localparam int TO = 4;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct {
        logic rst;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic load_e, br, wm, ww, req, rdy;
    } in_t;
    typedef struct {
        logic [3:0] st;
        logic [2:0] fl;
        int fa, fb, err, cs, cf, cl;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    int total = 0, bad = 0;
    exp_t q[$];
    int m_wait, m_waited, m_err, c_stall, c_flush, c_lu;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(CW)) bus ();
    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .hz(bus));

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
        end
    endtask

    function automatic int fwd_m(input logic [4:0] x, input in_t i);
        if (x == 0) return 0;
        if (i.wm && i.rd_m == x) return 2;
        if (i.ww && i.rd_w == x) return 1;
        return 0;
    endfunction

    function automatic int sat(input int v);
        return v > MAXC ? MAXC : v;
    endfunction

    function automatic in_t idle();
        in_t i;
        i = '{default: '0};
        return i;
    endfunction

    task automatic drive(input in_t i);
        rst = i.rst;
        bus.rs1_d = i.rs1_d; bus.rs2_d = i.rs2_d; bus.rs1_e = i.rs1_e; bus.rs2_e = i.rs2_e;
        bus.rd_e = i.rd_e; bus.rd_m = i.rd_m; bus.rd_w = i.rd_w;
        bus.load_e = i.load_e; bus.take_branch_e = i.br; bus.reg_write_m = i.wm;
        bus.reg_write_w = i.ww; bus.mem_req_m = i.req; bus.mem_ready_m = i.rdy;
    endtask

    task automatic step(input in_t i);
        exp_t e;
        bit ms, lu, br;
        @(posedge clk);
        #1;
        drive(i);
        ms = !i.rst && (m_wait != 0 ? !i.rdy : (i.req && !i.rdy));
        br = !i.rst && !ms && i.br;
        lu = !i.rst && !ms && !i.br && i.load_e && i.rd_e != 0 && (i.rd_e == i.rs1_d || i.rd_e == i.rs2_d);
        e.st = {ms || lu, ms || lu, ms, ms};
        e.fl = {br, br || lu, ms};
        e.fa = i.rst ? 0 : fwd_m(i.rs1_e, i);
        e.fb = i.rst ? 0 : fwd_m(i.rs2_e, i);
        e.err = m_err; e.cs = c_stall; e.cf = c_flush; e.cl = c_lu;
        q.push_back(e);
        if (i.rst) begin
            m_wait = 0; m_waited = 0; m_err = 0; c_stall = 0; c_flush = 0; c_lu = 0;
        end else begin
            c_stall = sat(c_stall + int'(ms || lu));
            c_flush = sat(c_flush + int'(br));
            c_lu = sat(c_lu + int'(lu));
            if (m_wait != 0) begin
                if (i.rdy) m_wait = 0;
                else begin
                    m_waited++;
                    if (m_waited == TO) begin
                        m_err = 1;
                        m_wait = 0;
                    end
                end
            end else if (i.req && !i.rdy) begin
                m_wait = 1;
                m_waited = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("stall_fdem", {28'd0, bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m}, e.st);
            check("flush_dew", {29'd0, bus.flush_d, bus.flush_e, bus.flush_w}, e.fl);
            check("forward_a_e", bus.forward_a_e, e.fa);
            check("forward_b_e", bus.forward_b_e, e.fb);
            check("mem_err", bus.mem_err, e.err);
            check("stall_cnt", bus.stall_cnt, e.cs);
            check("flush_cnt", bus.flush_cnt, e.cf);
            check("lu_cnt", bus.lu_cnt, e.cl);
        end
    end

    initial begin
        in_t i;
        drive(idle());
        rst = 1;
        repeat (3) @(posedge clk);
        m_wait = 0; m_waited = 0; m_err = 0; c_stall = 0; c_flush = 0; c_lu = 0;
        i = idle(); i.rst = 1; i.req = 1; i.load_e = 1; i.br = 1; i.rs1_e = 3; i.wm = 1; i.rd_m = 3;
        step(i);
        // forwarding: M over W, x0 never forwarded, W alone
        i = idle(); i.rd_m = 5; i.wm = 1; i.rd_w = 5; i.ww = 1; i.rs1_e = 5; step(i);
        i.rs1_e = 0; step(i);
        i.wm = 0; i.rs2_e = 5; step(i);
        // load-use then release
        i = idle(); i.load_e = 1; i.rd_e = 7; i.rs2_d = 7; step(i);
        step(idle());
        // branch overrides load-use
        i.br = 1; step(i);
        step(idle());
        i = idle(); i.rst = 1; step(i);
        // three-cycle memory wait
        i = idle(); i.req = 1;
        repeat (3) step(i);
        i.rdy = 1; step(i);
        step(idle());
        // timeout after TO wait cycles, mem_err sticky
        i = idle(); i.req = 1;
        repeat (TO + 1) step(i);
        repeat (3) step(idle());
        // saturating lu_cnt
        i = idle(); i.load_e = 1; i.rd_e = 4; i.rs1_d = 4;
        repeat (10) begin
            step(i);
            step(idle());
        end
        @(negedge clk);
        #1;
        check("lu_cnt_saturated", bus.lu_cnt, MAXC);
        // reset during MEM_WAIT
        i = idle(); i.req = 1;
        repeat (2) step(i);
        i.rst = 1; step(i);
        repeat (2) step(idle());
        for (int n = 0; n < 600; n++) begin
            i.rst = $urandom_range(0, 49) == 0;
            i.rs1_d = 5'($urandom_range(0, 3)); i.rs2_d = 5'($urandom_range(0, 3));
            i.rs1_e = 5'($urandom_range(0, 3)); i.rs2_e = 5'($urandom_range(0, 3));
            i.rd_e = 5'($urandom_range(0, 3)); i.rd_m = 5'($urandom_range(0, 3));
            i.rd_w = 5'($urandom_range(0, 3));
            i.load_e = $urandom_range(0, 9) < 4; i.br = $urandom_range(0, 9) < 2;
            i.wm = $urandom_range(0, 1) == 1; i.ww = $urandom_range(0, 1) == 1;
            i.req = $urandom_range(0, 9) < 3; i.rdy = $urandom_range(0, 9) < 3;
            step(i);
        end
        @(negedge clk);
        #1;
        check("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
